// File: rtl/keccak_pkg.sv
// Shared constants for the Keccak input padder: standard rates, domain
// separation bytes and the padder state encoding.
package keccak_pkg;

    localparam int RATE_224 = 1152;
    localparam int RATE_256 = 1088;
    localparam int RATE_384 = 832;
    localparam int RATE_512 = 576;

    localparam logic [7:0] DSB_KECCAK = 8'h01;
    localparam logic [7:0] DSB_SHA3   = 8'h06;
    localparam logic [7:0] PAD_END    = 8'h80;

    localparam logic [1:0] ST_ABSORB = 2'd0;
    localparam logic [1:0] ST_PAD    = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/keccak_pad_word.sv
// Builds one W-bit word for the block register: passes data through, or
// truncates to byte_num bytes and appends the domain byte and final 0x80 bit.
module keccak_pad_word
    import keccak_pkg::*;
#(
    parameter int         W   = 32,
    parameter logic [7:0] DSB = DSB_KECCAK,
    localparam int        BW  = $clog2(W/8)
) (
    input  logic [W-1:0]  in,
    input  logic [BW-1:0] byte_num,
    input  logic          is_last,
    input  logic          is_final_slot,
    output logic [W-1:0]  word
);
    localparam int NB = W / 8;

    always_comb begin
        // NOTE: default assignment first so no path leaves word unassigned (no latch).
        word = '0;
        // Byte 0 is the most-significant byte, matching the host byte order.
        for (int k = 0; k < NB; k++) begin
            if (!is_last || (BW'(k) < byte_num))
                word[W-1-8*k -: 8] = in[W-1-8*k -: 8];
            else if (BW'(k) == byte_num)
                word[W-1-8*k -: 8] = DSB;
        end
        if (is_final_slot)
            word[7:0] = word[7:0] | PAD_END;
    end

endmodule

// File: rtl/keccak_padder_param.sv
// Packs a W-bit message stream into RATE-bit blocks and applies multi-rate
// padding with a configurable domain-separation byte.
module keccak_padder_param
    import keccak_pkg::*;
#(
    parameter int         W    = 32,
    parameter int         RATE = RATE_512,
    parameter logic [7:0] DSB  = DSB_KECCAK,
    localparam int        BW   = $clog2(W/8)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W-1:0]    in,
    input  logic            in_ready,
    input  logic            is_last,
    input  logic [BW-1:0]   byte_num,
    output logic            buffer_full,
    output logic [RATE-1:0] out,
    output logic            out_ready,
    output logic            out_last,
    input  logic            f_ack
);
    localparam int            SLOTS     = RATE / W;
    localparam int            CW        = $clog2(SLOTS + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          last_flag;
    logic          accept;
    logic          insert;
    logic          pad_last;
    logic          final_slot;
    logic [W-1:0]  pad_in;
    logic [W-1:0]  word;

    assign buffer_full = (state == ST_FULL);
    assign out_ready   = (state == ST_FULL);
    assign out_last    = out_ready & last_flag;

    assign accept     = (state == ST_ABSORB) && in_ready && !buffer_full;
    assign insert     = accept || (state == ST_PAD);
    assign pad_in     = (state == ST_PAD) ? '0 : in;
    assign pad_last   = accept && is_last;
    // The 0x80 end bit only belongs to the last slot of the final block.
    assign final_slot = (count == LAST_SLOT) && ((state == ST_PAD) || pad_last);

    keccak_pad_word #(.W(W), .DSB(DSB)) u_pad_word (
        .in            (pad_in),
        .byte_num      (byte_num),
        .is_last       (pad_last),
        .is_final_slot (final_slot),
        .word          (word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_ABSORB;
            count     <= '0;
            last_flag <= 1'b0;
            out       <= '0;
        end else begin
            if (insert) begin
                out   <= {out[RATE-W-1:0], word};
                count <= count + 1'b1;
            end
            case (state)
                ST_ABSORB: begin
                    if (accept) begin
                        if (is_last)
                            last_flag <= 1'b1;
                        if (count == LAST_SLOT)
                            state <= ST_FULL;
                        else if (is_last)
                            state <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (count == LAST_SLOT)
                        state <= ST_FULL;
                end
                ST_FULL: begin
                    if (f_ack) begin
                        count <= '0;
                        state <= last_flag ? ST_DONE : ST_ABSORB;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/keccak_padder_param.md
Name: keccak_padder_param

Overview:
Parametrised successor to the fixed 32-bit/576-bit Keccak input padder. It accepts a message as a stream of W-bit words with byte_num/is_last framing and packs them into RATE-bit blocks. It applies multi-rate padding with a configurable domain-separation byte, so one block serves Keccak-n (0x01) and SHA3-n (0x06). Sits between the host stream and the f_permutation core, which consumes blocks via out_ready/f_ack.

Parameters:
W, 32, input word width in bits; 32 or 64; RATE must be a multiple of W
RATE, 576, block (rate) width in bits; 1152/1088/832/576 for 224/256/384/512
DSB, 8'h01, domain-separation pad byte; 8'h01 Keccak, 8'h06 SHA3
BW, $clog2(W/8), derived width of byte_num (localparam)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
in  in  W  message word; valid bytes are the most-significant bytes
in_ready  in  1  word valid; accepted on a clock edge when buffer_full=0 and state=ABSORB
is_last  in  1  with in_ready: final word of the message
byte_num  in  BW  with is_last: valid byte count 0..W/8-1; 0 means the word carries no data
buffer_full  out  1  block register holds RATE/W words; upstream must hold off
out  out  RATE  packed block; first word in out[RATE-1 -: W]
out_ready  out  1  out is a complete block for the permutation core
out_last  out  1  with out_ready: block is the final padded block
f_ack  in  1  one-cycle pulse from the core: block consumed

Behaviour:
- Reset (reset=0 at an edge): out=0, count=0, buffer_full=0, out_ready=0, out_last=0, state=ABSORB. Reset aborts any operation, including mid-block and mid-pad.
- States: ABSORB, PAD, FULL, DONE. count runs 0..RATE/W.
- Word insertion: out <= {out[RATE-W-1:0], word}; count++.
- ABSORB, accept (in_ready & ~buffer_full): the word is in unchanged when is_last=0.
- With is_last=1, the word keeps the byte_num top bytes of in, byte byte_num = DSB, lower bytes 0. If this word fills slot RATE/W-1, its LSB byte is OR'ed with 0x80. DSB always fits because byte_num < W/8.
- After an is_last accept: go to PAD if the block is not full; otherwise go to FULL with last flag set.
- PAD: insert one zero word per cycle, regardless of in_ready. The word filling the final slot has LSB byte = 0x80. Then go to FULL with last flag set.
- FULL is entered when count reaches RATE/W. buffer_full=out_ready=1 from the cycle after the filling edge. out_last = last flag.
- FULL + f_ack: count=0, buffer_full=out_ready=0 next cycle. Go to DONE if the last flag is set, else ABSORB.
- f_ack outside FULL is ignored.
- in_ready during FULL is not accepted, even in the same cycle as f_ack. Upstream re-presents the word.
- DONE: all inputs ignored except reset. out holds its value, out_ready=0.
- Throughput: one word per cycle. Latency from the last accept (or last pad insert) to out_ready is 1 cycle.

Decomposition:
- Package keccak_pkg: rate constants (RATE_224/256/384/512), DSB_KECCAK=8'h01, DSB_SHA3=8'h06, state enum.
- Sub-module keccak_pad_word: combinational; inputs in, byte_num, is_last, is_final_slot; output padded W-bit word. Reused in PAD with in=0, is_last=0.

Test Plan:
- W=32, RATE=576, DSB=01; "Hell","o, w","orld", then is_last with byte_num=0 -> out_ready after 18 words. out[575:480]="Hello, world", out[479:448]=32'h01000000, out[31:0]=32'h00000080, out_last=1.
- Same config; 17 data words, then "dog " with byte_num=3 and is_last -> final word=32'h646F6781, no PAD cycles, out_last=1.
- 18 words, no is_last -> out_ready=1, out_last=0, buffer_full=1. in_ready is ignored until f_ack. After f_ack, the 19th word lands in the new block and the old contents are shifted out.
- W=64, RATE=1088, DSB=06; "Hello Wo" then is_last with byte_num=3 and in="rld…" -> word 2 = 64'h726C64_06_00000000. Last word LSB=0x80. out_ready after 17 slots.
- reset=0 at word 5 of a block -> next cycle out=0, count=0, out_ready=0. A fresh message hashes identically to a clean run.
- After the final block is acked -> DONE. in_ready/is_last pulses produce no out_ready until reset.
